// File: rtl/dom_rnd_feeder.sv
// Fresh-randomness feeder for a paired GF(4) DOM multiplier: a seeded 64-bit LFSR that
// advances OUT_W steps per consumed word, and never presents a word twice.
module dom_rnd_feeder #(
    parameter int unsigned SHARES        = 2,
    parameter int unsigned BLIND_NRND    = 1,
    parameter int unsigned WARMUP_CYCLES = 4,
    localparam int unsigned Z_W          = 2 * SHARES * (SHARES - 1),
    localparam int unsigned B_W          = 4 * BLIND_NRND,
    localparam int unsigned OUT_W        = 2 * Z_W + B_W
) (
    input  logic             ClkxCI,
    input  logic             RstxRI,
    input  logic [63:0]      SeedxDI,
    input  logic             SeedValidxSI,
    output logic             SeedReadyxSO,
    output logic [OUT_W-1:0] RndxDO,
    output logic             RndValidxSO,
    input  logic             RndReadyxSI,
    output logic             SeededxSO
);

    if (OUT_W > 64) begin : gen_width_check
        $error("dom_rnd_feeder: OUT_W must not exceed the 64-bit LFSR width");
    end
    if (WARMUP_CYCLES > 255) begin : gen_warmup_check
        $error("dom_rnd_feeder: WARMUP_CYCLES must fit the 8-bit warm-up counter");
    end

    typedef enum logic [1:0] {StUnseeded, StWarmup, StRun} state_e;

    state_e      StatexDP;
    logic [63:0] LfsrxDP;
    logic [63:0] LfsrAdvxD;
    logic [7:0]  CntxDP;
    logic        RndValidxSP;
    logic        SeededxSP;

    // OUT_W single steps of x^64+x^63+x^61+x^60+1, unrolled into one clock.
    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    assign LfsrAdvxD = advance(LfsrxDP);

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            StatexDP    <= StUnseeded;
            LfsrxDP     <= '0;
            CntxDP      <= '0;
            RndValidxSP <= 1'b0;
            SeededxSP   <= 1'b0;
        end else if (SeedValidxSI) begin
            // Seed load wins over any advance; a consumed word is simply replaced.
            LfsrxDP   <= (SeedxDI == 64'h0) ? 64'h1 : SeedxDI;
            CntxDP    <= 8'(WARMUP_CYCLES);
            SeededxSP <= 1'b1;
            if (WARMUP_CYCLES > 0) begin
                StatexDP    <= StWarmup;
                RndValidxSP <= 1'b0;
            end else begin
                StatexDP    <= StRun;
                RndValidxSP <= 1'b1;
            end
        end else begin
            unique case (StatexDP)
                StWarmup: begin
                    LfsrxDP <= LfsrAdvxD;
                    CntxDP  <= CntxDP - 8'd1;
                    if (CntxDP == 8'd1) begin
                        StatexDP    <= StRun;
                        RndValidxSP <= 1'b1;
                    end
                end
                StRun: begin
                    if (RndReadyxSI) begin
                        LfsrxDP <= LfsrAdvxD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SeedReadyxSO = ~RstxRI;
    assign RndxDO       = LfsrxDP[OUT_W-1:0];
    assign RndValidxSO  = RndValidxSP;
    assign SeededxSO    = SeededxSP;

endmodule

// File: tb/tb_dom_rnd_feeder.sv
// Directed bench: three feeders (warm-up 0, 2, 4) share one stimulus stream and are
// checked against hand-computed constants and an LFSR reference model.
module tb_dom_rnd_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seed;
    logic        seedV;
    logic        rndRdy;

    logic        sr0, sr2, sr4;
    logic [11:0] r0, r2, r4;
    logic        v0, v2, v4;
    logic        sd0, sd2, sd4;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] s0, s2, s4;

    always #5 clk = ~clk;

    dom_rnd_feeder #(.WARMUP_CYCLES(0)) dut0 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .SeedReadyxSO(sr0), .RndxDO(r0), .RndValidxSO(v0), .RndReadyxSI(rndRdy),
        .SeededxSO(sd0)
    );
    dom_rnd_feeder #(.WARMUP_CYCLES(2)) dut2 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .SeedReadyxSO(sr2), .RndxDO(r2), .RndValidxSO(v2), .RndReadyxSI(rndRdy),
        .SeededxSO(sd2)
    );
    dom_rnd_feeder #(.WARMUP_CYCLES(4)) dut4 (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed), .SeedValidxSI(seedV),
        .SeedReadyxSO(sr4), .RndxDO(r4), .RndValidxSO(v4), .RndReadyxSI(rndRdy),
        .SeededxSO(sd4)
    );

    // Reference: twelve steps of f = S[63]^S[62]^S[60]^S[59], shifted in at the bottom.
    function automatic logic [63:0] adv(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 12; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        seed   = 64'h0;
        seedV  = 1'b0;
        rndRdy = 1'b1;
        repeat (3) tick();
        chk("rst_seed_ready", sr0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_seeded", sd0, 0);
        chk("rst_rnd", r0, 0);

        rst = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("idle_seed_ready0", sr0, 1);
            chk("idle_seed_ready2", sr2, 1);
            chk("idle_seed_ready4", sr4, 1);
            chk("idle_valid0", v0, 0);
            chk("idle_valid2", v2, 0);
            chk("idle_valid4", v4, 0);
            chk("idle_seeded", sd0, 0);
            chk("idle_rnd", r0, 0);
            tick();
        end

        // Seed 0xABC accepted at edge t.
        rndRdy = 1'b0;
        seed   = 64'hABC;
        seedV  = 1'b1;
        tick();
        seedV  = 1'b0;
        chk("abc_w0_valid", v0, 1);
        chk("abc_w0_rnd", r0, 12'hABC);
        chk("abc_w2_valid_t1", v2, 0);
        chk("abc_w4_valid_t1", v4, 0);
        chk("abc_seeded0", sd0, 1);
        chk("abc_seeded2", sd2, 1);
        chk("abc_seeded4", sd4, 1);

        rndRdy = 1'b1;
        tick();
        rndRdy = 1'b0;
        chk("abc_w0_after_take", r0, 12'h000);
        chk("abc_w0_valid_after_take", v0, 1);
        chk("abc_w2_valid_t2", v2, 0);
        tick();
        chk("abc_w2_valid_t3", v2, 1);
        chk("abc_w2_rnd_t3", r2, 12'h000);
        chk("abc_w4_valid_t3", v4, 0);
        tick();
        chk("abc_w4_valid_t4", v4, 0);
        tick();
        chk("abc_w4_valid_t5", v4, 1);
        chk("abc_w4_rnd_t5", r4, 12'h000);

        s0 = 64'hABC000;
        s2 = 64'hABC000000;
        s4 = 64'h0ABC000000000000;

        for (int i = 0; i < 10; i++) begin
            chk("hold_rnd0", r0, s0[11:0]);
            chk("hold_valid0", v0, 1);
            chk("hold_rnd4", r4, s4[11:0]);
            tick();
        end

        rndRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            s0 = adv(s0);
            s2 = adv(s2);
            s4 = adv(s4);
            chk("burst_rnd0", r0, s0[11:0]);
            chk("burst_rnd2", r2, s2[11:0]);
            chk("burst_rnd4", r4, s4[11:0]);
        end
        rndRdy = 1'b0;
        tick();
        chk("burst_stop_rnd2", r2, s2[11:0]);
        chk("burst_stop_rnd4", r4, s4[11:0]);
        tick();
        chk("burst_stop_rnd4_hold", r4, s4[11:0]);

        // A zero seed must load as 1.
        seed  = 64'h0;
        seedV = 1'b1;
        tick();
        seedV = 1'b0;
        chk("zero_seed_valid", v0, 1);
        chk("zero_seed_rnd", r0, 12'h001);
        s0 = 64'h1;
        s2 = adv(adv(64'h1));
        s4 = adv(adv(adv(adv(64'h1))));
        repeat (4) tick();
        chk("zero_seed_w2_valid", v2, 1);
        chk("zero_seed_w4_valid", v4, 1);
        chk("zero_seed_w4_rnd", r4, s4[11:0]);

        for (int i = 0; i < 10000; i++) begin
            rndRdy = 1'($urandom_range(0, 1));
            tick();
            if (rndRdy) begin
                s0 = adv(s0);
                s2 = adv(s2);
                s4 = adv(s4);
            end
            chk("rand_rnd0", r0, s0[11:0]);
            chk("rand_rnd2", r2, s2[11:0]);
            chk("rand_rnd4", r4, s4[11:0]);
        end
        chk("rand_valid0", v0, 1);
        chk("rand_valid4", v4, 1);

        // Reseed in RUN together with a consumer transfer.
        rndRdy = 1'b1;
        seed   = 64'h123456789ABCDEF0;
        seedV  = 1'b1;
        tick();
        seedV  = 1'b0;
        rndRdy = 1'b0;
        chk("reseed_w0_valid", v0, 1);
        chk("reseed_w0_rnd", r0, 12'hEF0);
        chk("reseed_w2_valid_t1", v2, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("reseed_w4_valid_low", v4, 0);
            if (k >= 3) chk("reseed_w2_valid_high", v2, 1);
            tick();
        end
        chk("reseed_w4_valid_t5", v4, 1);
        chk("reseed_w4_rnd_t5", r4, 12'(adv(adv(adv(adv(seed))))));
        chk("reseed_w2_rnd", r2, 12'(adv(adv(seed))));

        // Reset while in warm-up.
        seed  = 64'h5;
        seedV = 1'b1;
        tick();
        seedV = 1'b0;
        chk("warm_rst_pre_valid", v4, 0);
        chk("warm_rst_pre_seeded", sd4, 1);
        rst = 1'b1;
        tick();
        chk("warm_rst_seeded", sd4, 0);
        chk("warm_rst_valid", v4, 0);
        chk("warm_rst_rnd", r4, 0);
        chk("warm_rst_seed_ready", sr4, 0);
        chk("warm_rst_w0_valid", v0, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_seeded", sd4, 0);
        chk("post_rst_seed_ready", sr4, 1);
        chk("post_rst_valid", v4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dom_rnd_feeder.md
# dom_rnd_feeder

Fresh-randomness source for the masked AES S-box datapath. It expands a software-supplied seed with a 64-bit LFSR and delivers, per accepted transfer, one word containing the remask randomness Z1 and Z2 and the blinding randomness B that one paired GF(4) DOM multiplier consumes in a cycle. It sits directly upstream of the paired multiplier. It guarantees that no random word is ever presented twice, and that no output is produced before seeding and warm-up.

## Interface
- SHARES, 2: number of shares; sets Z_W = 2*SHARES*(SHARES-1).
- BLIND_NRND, 1: number of 4-bit blinding nibbles; B_W = 4*BLIND_NRND.
- WARMUP_CYCLES, 4: number of discard cycles after each seed load; 0..255 legal.
- Derived: OUT_W = 2*Z_W + B_W (12 at defaults). OUT_W ≤ 64 is checked at elaboration.
- ClkxCI  in  1  clock; all state updates on the rising edge.
- RstxRI  in  1  reset, synchronous, active-high.
- SeedxDI  in  64  seed value.
- SeedValidxSI  in  1  seed offered.
- SeedReadyxSO  out  1  seed can be accepted.
- RndxDO  out  OUT_W  random word. Bit fields:
  - [Z_W-1:0] is Z1.
  - [2*Z_W-1:Z_W] is Z2.
  - [OUT_W-1:2*Z_W] is B.
- RndValidxSO  out  1  RndxDO holds fresh, never-consumed randomness.
- RndReadyxSI  in  1  consumer takes RndxDO this cycle.
- SeededxSO  out  1  at least one seed has been loaded since reset.

## Operation
- State: 64-bit LFSR S, FSM {UNSEEDED, WARMUP, RUN}, 8-bit warm-up counter C.
- One LFSR step:
  - f = S[63]^S[62]^S[60]^S[59] (polynomial x^64+x^63+x^61+x^60+1).
  - S <= {S[62:0], f}.
  - An "advance" is OUT_W consecutive steps, unrolled combinationally, performed in one clock.
- RndxDO = S[OUT_W-1:0], driven combinationally from the registered S. It is meaningful only while RndValidxSO = 1.
- Seed load: a seed transfer happens when SeedValidxSI & SeedReadyxSO.
  - On a transfer, S <= SeedxDI, except that a seed of 0 is replaced by 64'h1 (avoids the lock-up state).
  - C <= WARMUP_CYCLES.
  - Next state is WARMUP if WARMUP_CYCLES > 0, else RUN.
- SeedReadyxSO = 1 in every state when not in reset. Reseeding is allowed at any time.
- FSM behaviour:
  - UNSEEDED: S is held. RndValidxSO = 0. Leaves only on a seed transfer.
  - WARMUP: each cycle, S advances and C decrements. When C reaches 1, the next state is RUN. RndValidxSO = 0.
  - RUN: RndValidxSO = 1. S advances only on a consumer transfer (RndValidxSO & RndReadyxSI). With RndReadyxSI = 0, RndxDO is held stable indefinitely.
- Simultaneous seed transfer and consumer transfer in RUN:
  - The consumer transfer completes; the current word counts as consumed.
  - The seed load takes priority over the advance.
- A seed transfer during WARMUP restarts warm-up from the new seed.
- SeededxSO: set on the first seed transfer after reset; cleared only by reset.

## Timing
- Reset (RstxRI = 1 at an edge) puts the block in UNSEEDED with S = 0 and C = 0. After reset, all outputs read:
  - RndValidxSO = 0
  - SeededxSO = 0
  - RndxDO = 0
  - SeedReadyxSO = 0 (low while RstxRI is asserted; high from the first cycle after reset)
- Reset mid-operation (WARMUP or RUN) discards S, including any word being consumed in that cycle. The block requires a new seed.
- Seed transfer in cycle t:
  - SeededxSO = 1 from cycle t+1.
  - RndValidxSO = 1 from cycle t+1+WARMUP_CYCLES.
  - If the transfer happened in RUN with WARMUP_CYCLES > 0, RndValidxSO falls in cycle t+1.
- Consumer transfer in cycle t: the next word appears in cycle t+1. RndValidxSO stays 1, giving full throughput of one word per cycle.
- No output is combinationally dependent on RndReadyxSI or SeedValidxSI.

## Test plan
- Reset, no seed, RndReadyxSI = 1 for 20 cycles -> RndValidxSO = 0, SeededxSO = 0 and RndxDO = 0 throughout; SeedReadyxSO = 1 from the first cycle after reset.
- WARMUP_CYCLES = 0, seed 64'hABC accepted in cycle t:
  - cycle t+1: RndValidxSO = 1, RndxDO = 12'hABC;
  - after one consumer transfer: RndxDO = 12'h000 and S = 64'hABC000.
- WARMUP_CYCLES = 2, seed 64'hABC -> RndValidxSO = 0 in cycles t+1 and t+2; cycle t+3: RndValidxSO = 1, S = 64'hABC000000, RndxDO = 12'h000.
- Seed 64'h0 -> S loads 64'h1; with WARMUP_CYCLES = 0, RndxDO = 12'h001.
- RUN with RndReadyxSI = 0 for 10 cycles -> RndxDO unchanged. Then assert RndReadyxSI for 3 cycles -> exactly 3 advances. A reference model checks that no word is ever presented twice, across a 10k-cycle random-ready run.
- Mid-operation events:
  - Reseed in RUN (WARMUP_CYCLES = 4) in the same cycle as a consumer transfer -> RndValidxSO = 0 for cycles t+1..t+4; the new seed's stream begins at t+5.
  - RstxRI asserted in WARMUP -> UNSEEDED, SeededxSO = 0 on the next cycle.
